// File: rtl/multi_beat_generator.sv
// Multi-channel beat generator: per-channel periodic pulse, bar position
// and downbeat, with periods taken from a shared runtime-writable table.
module multi_beat_generator #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 28,
    parameter int SEL_W         = 3,
    parameter int PULSE_LEN     = 1,
    parameter int BEATS_PER_BAR = 4,
    localparam int BW           = $clog2(BEATS_PER_BAR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH*SEL_W-1:0] sel,
    input  logic                  sync,
    input  logic                  tbl_we,
    input  logic [SEL_W-1:0]      tbl_addr,
    input  logic [CNT_W-1:0]      tbl_data,
    output logic [N_CH-1:0]       pulse,
    output logic [N_CH-1:0]       downbeat,
    output logic [N_CH*BW-1:0]    beat_idx
);

    localparam int DEPTH = 1 << SEL_W;
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] PL  = CNT_W'(PULSE_LEN);
    localparam logic [BW-1:0]    LAST = BW'(BEATS_PER_BAR - 1);

    function automatic logic [CNT_W-1:0] tbl_default(input int i);
        case (i)
            0:       return CNT_W'(100);
            1:       return CNT_W'(66);
            2:       return CNT_W'(50);
            3:       return CNT_W'(40);
            4:       return CNT_W'(30);
            5:       return CNT_W'(20);
            6:       return CNT_W'(12);
            default: return CNT_W'(6);
        endcase
    endfunction

    logic [CNT_W-1:0] tbl [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[SEL_W'(i)] <= tbl_default(i);
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SEL_W-1:0] s;
        logic [SEL_W-1:0] sel_q;
        logic [CNT_W-1:0] cnt;
        logic [BW-1:0]    bidx;
        logic             run;
        logic [CNT_W-1:0] ent;
        logic [CNT_W-1:0] pe;
        logic [CNT_W-1:0] ent_q;
        logic [CNT_W-1:0] pe_q;
        logic [CNT_W-1:0] ple;

        assign s     = sel[c*SEL_W +: SEL_W];
        assign ent   = tbl[s];
        assign pe    = (ent < TWO) ? TWO : ent;
        // Width decode uses the registered select so outputs depend on state only
        assign ent_q = tbl[sel_q];
        assign pe_q  = (ent_q < TWO) ? TWO : ent_q;
        assign ple   = (PL < pe_q - 1'b1) ? PL : pe_q - 1'b1;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sel_q <= '0;
                cnt   <= '0;
                bidx  <= '0;
                run   <= 1'b0;
            end else begin
                sel_q <= s;
                if (!en[c]) begin
                    cnt  <= '0;
                    bidx <= '0;
                    run  <= 1'b0;
                end else if (!run) begin
                    run <= 1'b1;
                end else if (sync || (s != sel_q)) begin
                    cnt  <= '0;
                    bidx <= '0;
                end else if (cnt >= pe - 1'b1) begin
                    cnt  <= '0;
                    bidx <= (bidx == LAST) ? '0 : bidx + BW'(1);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign pulse[c]              = run && (cnt < ple);
        assign downbeat[c]           = pulse[c] && (bidx == '0);
        assign beat_idx[c*BW +: BW]  = bidx;
    end

endmodule

// File: tb/tb_multi_beat_generator.sv
// Directed bench for multi_beat_generator: two builds (PULSE_LEN 1 and 3)
// driven in lockstep, expectations queued and checked after each edge.
module tb_multi_beat_generator;

    logic        clk;
    logic        reset;
    logic [3:0]  en;
    logic [11:0] sel;
    logic        sync;
    logic        tbl_we;
    logic [2:0]  tbl_addr;
    logic [27:0] tbl_data;
    logic [3:0]  pulse1, down1, pulse3, down3;
    logic [7:0]  bidx1, bidx3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int    d;
        int    c;
        bit    p;
        bit    db;
        int    b;
        string tag;
    } exp_t;

    exp_t sb[$];

    multi_beat_generator u1 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .sync(sync),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .pulse(pulse1), .downbeat(down1), .beat_idx(bidx1)
    );

    multi_beat_generator #(.PULSE_LEN(3)) u3 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .sync(sync),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .pulse(pulse3), .downbeat(down3), .beat_idx(bidx3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_ch(input int d, input int c, input bit p,
                             input int b, input string tag);
        exp_t e;
        e.d = d; e.c = c; e.p = p; e.db = p && (b == 0); e.b = b; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        logic ap, ad;
        int   ab;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            ap = (e.d == 0) ? pulse1[e.c] : pulse3[e.c];
            ad = (e.d == 0) ? down1[e.c]  : down3[e.c];
            ab = (e.d == 0) ? int'(bidx1[e.c*2 +: 2]) : int'(bidx3[e.c*2 +: 2]);
            checks++;
            assert (ap === e.p) else begin
                errors++;
                $error("FAIL %s d%0d ch%0d pulse: got %b want %b", e.tag, e.d, e.c, ap, e.p);
            end
            checks++;
            assert (ad === e.db) else begin
                errors++;
                $error("FAIL %s d%0d ch%0d downbeat: got %b want %b", e.tag, e.d, e.c, ad, e.db);
            end
            checks++;
            assert (ab === e.b) else begin
                errors++;
                $error("FAIL %s d%0d ch%0d beat_idx: got %0d want %0d", e.tag, e.d, e.c, ab, e.b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic set_sel(input int c, input int v);
        sel[c*3 +: 3] = 3'(v);
    endtask

    initial begin
        reset    = 1'b0;
        en       = '0;
        sel      = '0;
        sync     = 1'b0;
        tbl_we   = 1'b0;
        tbl_addr = '0;
        tbl_data = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            expect_ch(0, c, 0, 0, "reset");
            expect_ch(1, c, 0, 0, "reset");
        end
        check_now();

        // default period 100 on ch0
        reset = 1'b1;
        en[0] = 1'b1;
        for (int k = 1; k <= 401; k++) begin
            expect_ch(0, 0, ((k - 1) % 100) == 0, ((k - 1) / 100) % 4, "sel0");
            expect_ch(1, 0, ((k - 1) % 100) < 3, ((k - 1) / 100) % 4, "sel0_pl3");
            tick();
        end

        // ch1 sel change at cnt=37
        en[1] = 1'b1;
        for (int m = 1; m <= 38; m++) begin
            expect_ch(0, 1, m == 1, 0, "ch1_pre");
            tick();
        end
        set_sel(1, 7);
        for (int j = 0; j <= 12; j++) begin
            expect_ch(0, 1, (j % 6) == 0, (j / 6) % 4, "selchg");
            expect_ch(1, 1, (j % 6) < 3, (j / 6) % 4, "selchg_pl3");
            tick();
        end

        // ch2 table shrink at cnt=30
        en[2] = 1'b1;
        set_sel(2, 2);
        for (int m = 1; m <= 31; m++) begin
            expect_ch(0, 2, m == 1, 0, "ch2_pre");
            tick();
        end
        tbl_we   = 1'b1;
        tbl_addr = 3'd2;
        tbl_data = 28'd10;
        expect_ch(0, 2, 0, 0, "wr_edge");
        tick();
        tbl_we = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            expect_ch(0, 2, (j % 10) == 0, (1 + j / 10) % 4, "shrink");
            tick();
        end

        // entry 1 then 0: period clamps to 2
        en[2]    = 1'b0;
        tbl_we   = 1'b1;
        tbl_data = 28'd1;
        expect_ch(0, 2, 0, 0, "en_off");
        tick();
        tbl_we = 1'b0;
        en[2]  = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            if (j == 9) begin
                tbl_we   = 1'b1;
                tbl_data = 28'd0;
            end
            expect_ch(0, 2, (j % 2) == 0, (j / 2) % 4, "p2");
            expect_ch(1, 2, (j % 2) == 0, (j / 2) % 4, "p2_pl3");
            tick();
            tbl_we = 1'b0;
        end

        // misaligned ch0 (40) and ch1 (20), then sync
        en[2] = 1'b0;
        set_sel(0, 3);
        tick();
        repeat (7) tick();
        set_sel(1, 5);
        repeat (13) tick();
        sync = 1'b1;
        for (int j = 0; j <= 80; j++) begin
            expect_ch(0, 0, (j % 40) == 0, (j / 40) % 4, "sync0");
            expect_ch(1, 0, (j % 40) < 3, (j / 40) % 4, "sync0_pl3");
            expect_ch(0, 1, (j % 20) == 0, (j / 20) % 4, "sync1");
            expect_ch(0, 2, 0, 0, "sync2_off");
            expect_ch(0, 3, 0, 0, "sync3_off");
            tick();
            sync = 1'b0;
        end

        // ch1 disable / re-enable, ch0 unaffected
        en[1] = 1'b0;
        for (int j = 81; j <= 85; j++) begin
            expect_ch(0, 1, 0, 0, "en_drop");
            expect_ch(0, 0, (j % 40) == 0, (j / 40) % 4, "en_drop_ch0");
            tick();
        end
        en[1] = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            expect_ch(0, 1, (i % 20) == 0, (i / 20) % 4, "en_rise");
            expect_ch(0, 0, ((86 + i) % 40) == 0, ((86 + i) / 40) % 4, "en_rise_ch0");
            tick();
        end

        // async reset while ch1 pulse is high
        #2;
        reset = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            expect_ch(0, c, 0, 0, "async_rst");
            expect_ch(1, c, 0, 0, "async_rst");
        end
        check_now();
        en = 4'b0100;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            expect_ch(0, 2, ((k - 1) % 50) == 0, ((k - 1) / 50) % 4, "tbl_default");
            expect_ch(0, 0, 0, 0, "post_rst_ch0");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
